ex_alu_csr_unit: RTL and testbench
==================================

Name: ex_alu_csr_unit

Overview:
Execute-stage compute block for the RV32I pipeline. It combines three functions:
- ALU-control decode: alu_op, func3 and func7 select a 4-bit operation.
- A 32-bit integer ALU with a branch-compare flag.
- A small machine/supervisor CSR register file, with one synchronous write port and one combinational read port.

Operand forwarding and muxing stay in stage_ex, outside this block.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_op  in  3  operation class: 000 ADD, 001 BRANCH, 010 R-type, 011 I-type arith; 1xx decodes as ADD.
- func3_code  in  3  instruction func3.
- func7_code  in  1  instruction bit 30.
- op_a  in  32  ALU operand A.
- op_b  in  32  ALU operand B.
- alu_ctrl  out  4  decoded ALU operation.
- alu_o  out  32  ALU result.
- br_mark  out  1  branch condition true.
- priv_mode  in  2  current privilege level: 11 M, 01 S, 00 U.
- csr_w_en  in  1  CSR write request.
- csr_w_addr  in  12  CSR write address.
- csr_w_data  in  32  CSR write data.
- csr_r_addr  in  12  CSR read address.
- csr_r_data  out  32  CSR read data.
- o_mtvec, o_mstatus, o_mepc, o_mtval, o_mcause, o_satp, o_sepc  out  32 each  direct views of the CSR registers.

Behaviour:
- ALU path is purely combinational, zero latency. CSR writes take effect at the next rising edge.
- alu_ctrl encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
- Decode for R-type (010), by func3:
  - 000: SUB if func7_code=1, else ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRA if func7_code=1, else SRL.
  - 110 OR, 111 AND.
- Decode for I-type (011): same as R-type, except func3=000 is always ADD (func7 ignored). func7 is honoured only for 101.
- Decode for BRANCH (001), by func3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. func3 010/011 decode to ADD.
- All other alu_op values decode to ADD. LUI is handled upstream with op_a=0.
- ALU arithmetic:
  - Results wrap modulo 2^32.
  - Shift amount is op_b[4:0]; SRA is an arithmetic shift.
  - SLT compares signed, SLTU unsigned; result is 0 or 1.
- Branch codes:
  - alu_o = op_a - op_b.
  - br_mark is the comparison result (signed compare for BLT/BGE, unsigned for BLTU/BGEU).
  - br_mark = 0 for every non-branch code.
- CSR map:
  - MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343, SATP 0x180, SEPC 0x141.
  - All registers are full 32-bit read/write and reset to 0.
- CSR write:
  - Occurs on a clk edge when csr_w_en=1 and the address is implemented.
  - Unimplemented addresses: write ignored, csr_r_data = 0 (no latch, no X).
- CSR read: combinational. A write and read to the same address in the same cycle returns the old value; the new value is visible the cycle after the edge.
- rst has priority over csr_w_en. Asserting rst mid-stream clears all CSRs at that edge.
- The ALU and decoder have no state and are unaffected by rst.

Optional Feature:
- Macro CSR_PRIV_CHECK_EN.
- Defined: a write commits only if priv_mode >= csr_w_addr[9:8]; otherwise it is silently dropped. Reads are always permitted.
- Undefined: every write to an implemented address commits regardless of priv_mode.

Decomposition:
- Shared package holds:
  - alu_op codes and alu_ctrl codes;
  - CSR address constants;
  - privilege-level constants (PRIV_M/S/U).
- One sub-module is natural: csr_regfile (registers, write decode, read mux, privilege check). Decoder and ALU stay in the top.

Test Plan:
1. ALU arithmetic, R-type: alu_op=010, func3=000, func7=1, op_a=5, op_b=7 -> alu_ctrl=1, alu_o=0xFFFFFFFE, br_mark=0.
2. Signed vs unsigned shift: SRA op_a=0x80000000, op_b=0x24 -> 0xF8000000. SRL, same operands -> 0x08000000.
3. Branch compare with op_a=0xFFFFFFFF, op_b=1:
   - BLT (001/100) -> br_mark=1.
   - BLTU (001/110) -> br_mark=0.
   - BEQ with equal operands -> br_mark=1.
4. CSR write/read: write 0x80001000 to MTVEC. csr_r_data at 0x305 is still 0 in the same cycle and 0x80001000 the next; o_mtvec matches. A read of 0x7C0 returns 0.
5. Reset priority: rst=1 and csr_w_en=1 to MEPC on the same edge -> o_mepc=0, and all other CSRs read 0.
6. CSR_PRIV_CHECK_EN defined: priv_mode=01, write to MSTATUS -> unchanged. Write to SEPC -> updated.

Source files
------------

// File: rtl/ex_alu_csr_unit_pkg.sv
// Shared constants for the execute-stage ALU/CSR block.
// alu_op classes, alu_ctrl codes, CSR addresses and privilege levels.
package ex_alu_csr_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] ALU_OP_ADD    = 3'b000;
   localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
   localparam logic [2:0] ALU_OP_RTYPE  = 3'b010;
   localparam logic [2:0] ALU_OP_ITYPE  = 3'b011;

   typedef enum logic [3:0] {
      CTRL_ADD  = 4'd0,
      CTRL_SUB  = 4'd1,
      CTRL_SLL  = 4'd2,
      CTRL_SLT  = 4'd3,
      CTRL_SLTU = 4'd4,
      CTRL_XOR  = 4'd5,
      CTRL_SRL  = 4'd6,
      CTRL_SRA  = 4'd7,
      CTRL_OR   = 4'd8,
      CTRL_AND  = 4'd9,
      CTRL_BEQ  = 4'd10,
      CTRL_BNE  = 4'd11,
      CTRL_BLT  = 4'd12,
      CTRL_BGE  = 4'd13,
      CTRL_BLTU = 4'd14,
      CTRL_BGEU = 4'd15
   } alu_ctrl_e;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_SATP    = 12'h180;
   localparam logic [11:0] CSR_SEPC    = 12'h141;

   localparam logic [1:0] PRIV_M = 2'b11;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_U = 2'b00;

endpackage

// File: rtl/ex_alu_csr_unit_if.sv
// Signal bundle between the execute stage and the ALU/CSR block.
// master = pipeline side (drives operands and CSR requests), slave = this block.
interface ex_alu_csr_unit_if;
   logic [2:0]  alu_op;
   logic [2:0]  func3_code;
   logic        func7_code;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_o;
   logic        br_mark;
   logic [1:0]  priv_mode;
   logic        csr_w_en;
   logic [11:0] csr_w_addr;
   logic [31:0] csr_w_data;
   logic [11:0] csr_r_addr;
   logic [31:0] csr_r_data;
   logic [31:0] o_mtvec;
   logic [31:0] o_mstatus;
   logic [31:0] o_mepc;
   logic [31:0] o_mtval;
   logic [31:0] o_mcause;
   logic [31:0] o_satp;
   logic [31:0] o_sepc;

   modport master (
      output alu_op, func3_code, func7_code, op_a, op_b,
      output priv_mode, csr_w_en, csr_w_addr, csr_w_data, csr_r_addr,
      input  alu_ctrl, alu_o, br_mark, csr_r_data,
      input  o_mtvec, o_mstatus, o_mepc, o_mtval, o_mcause, o_satp, o_sepc
   );

   modport slave (
      input  alu_op, func3_code, func7_code, op_a, op_b,
      input  priv_mode, csr_w_en, csr_w_addr, csr_w_data, csr_r_addr,
      output alu_ctrl, alu_o, br_mark, csr_r_data,
      output o_mtvec, o_mstatus, o_mepc, o_mtval, o_mcause, o_satp, o_sepc
   );
endinterface

// File: rtl/ex_alu_csr_unit_csr_regfile.sv
// Machine/supervisor CSR file: one synchronous write port, one combinational read port.
// Optional macro CSR_PRIV_CHECK_EN: drop writes whose address privilege (addr[9:8])
// exceeds the current privilege level.
module ex_alu_csr_unit_csr_regfile
   import ex_alu_csr_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  priv_mode_i,
   input  logic        w_en_i,
   input  logic [11:0] w_addr_i,
   input  logic [31:0] w_data_i,
   input  logic [11:0] r_addr_i,
   output logic [31:0] r_data_o,
   output logic [31:0] mstatus_o,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic [31:0] mcause_o,
   output logic [31:0] mtval_o,
   output logic [31:0] satp_o,
   output logic [31:0] sepc_o
);

   logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q, mtval_q, satp_q, sepc_q;
   logic [31:0] mstatus_d, mtvec_d, mepc_d, mcause_d, mtval_d, satp_d, sepc_d;
   logic        priv_ok;
   logic        we;

`ifdef CSR_PRIV_CHECK_EN
   assign priv_ok = (priv_mode_i >= w_addr_i[9:8]);
`else
   logic unused_priv;
   assign unused_priv = ^priv_mode_i;
   assign priv_ok     = 1'b1;
`endif

   assign we = w_en_i & priv_ok;

   // Write decode: only the addressed, implemented register takes the new data.
   always_comb begin
      mstatus_d = mstatus_q;
      mtvec_d   = mtvec_q;
      mepc_d    = mepc_q;
      mcause_d  = mcause_q;
      mtval_d   = mtval_q;
      satp_d    = satp_q;
      sepc_d    = sepc_q;
      if (we) begin
         case (w_addr_i)
            CSR_MSTATUS: mstatus_d = w_data_i;
            CSR_MTVEC:   mtvec_d   = w_data_i;
            CSR_MEPC:    mepc_d    = w_data_i;
            CSR_MCAUSE:  mcause_d  = w_data_i;
            CSR_MTVAL:   mtval_d   = w_data_i;
            CSR_SATP:    satp_d    = w_data_i;
            CSR_SEPC:    sepc_d    = w_data_i;
            default: ;
         endcase
      end
   end

   // Register update; reset wins over a same-edge write.
   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_q <= '0;
         mtvec_q   <= '0;
         mepc_q    <= '0;
         mcause_q  <= '0;
         mtval_q   <= '0;
         satp_q    <= '0;
         sepc_q    <= '0;
      end else begin
         mstatus_q <= mstatus_d;
         mtvec_q   <= mtvec_d;
         mepc_q    <= mepc_d;
         mcause_q  <= mcause_d;
         mtval_q   <= mtval_d;
         satp_q    <= satp_d;
         sepc_q    <= sepc_d;
      end
   end

   // Read mux from the registered values, so a same-cycle write reads old data.
   always_comb begin
      r_data_o = '0;
      case (r_addr_i)
         CSR_MSTATUS: r_data_o = mstatus_q;
         CSR_MTVEC:   r_data_o = mtvec_q;
         CSR_MEPC:    r_data_o = mepc_q;
         CSR_MCAUSE:  r_data_o = mcause_q;
         CSR_MTVAL:   r_data_o = mtval_q;
         CSR_SATP:    r_data_o = satp_q;
         CSR_SEPC:    r_data_o = sepc_q;
         default:     r_data_o = '0;
      endcase
   end

   assign mstatus_o = mstatus_q;
   assign mtvec_o   = mtvec_q;
   assign mepc_o    = mepc_q;
   assign mcause_o  = mcause_q;
   assign mtval_o   = mtval_q;
   assign satp_o    = satp_q;
   assign sepc_o    = sepc_q;

endmodule

// File: rtl/ex_alu_csr_unit.sv
// Execute-stage compute block: ALU-control decode, 32-bit ALU with branch flag,
// and the CSR file. ALU path is combinational; only the CSRs hold state.
// Optional macro CSR_PRIV_CHECK_EN (handled in the CSR file) gates writes by privilege.
module ex_alu_csr_unit
   import ex_alu_csr_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic               clk,
   input logic               rst,
   ex_alu_csr_unit_if.slave  bus
);

   alu_ctrl_e       ctrl;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] diff;
   logic [4:0]      shamt;
   logic            lt_s;
   logic            lt_u;
   logic            br;

   // Decode the operation class and func fields into one ALU operation.
   always_comb begin
      ctrl = CTRL_ADD;
      case (bus.alu_op)
         ALU_OP_RTYPE, ALU_OP_ITYPE: begin
            case (bus.func3_code)
               3'b000: ctrl = (bus.alu_op == ALU_OP_RTYPE && bus.func7_code) ? CTRL_SUB : CTRL_ADD;
               3'b001: ctrl = CTRL_SLL;
               3'b010: ctrl = CTRL_SLT;
               3'b011: ctrl = CTRL_SLTU;
               3'b100: ctrl = CTRL_XOR;
               3'b101: ctrl = bus.func7_code ? CTRL_SRA : CTRL_SRL;
               3'b110: ctrl = CTRL_OR;
               default: ctrl = CTRL_AND;
            endcase
         end
         ALU_OP_BRANCH: begin
            case (bus.func3_code)
               3'b000: ctrl = CTRL_BEQ;
               3'b001: ctrl = CTRL_BNE;
               3'b100: ctrl = CTRL_BLT;
               3'b101: ctrl = CTRL_BGE;
               3'b110: ctrl = CTRL_BLTU;
               3'b111: ctrl = CTRL_BGEU;
               default: ctrl = CTRL_ADD;
            endcase
         end
         default: ctrl = CTRL_ADD;
      endcase
   end

   assign diff  = bus.op_a - bus.op_b;
   assign shamt = bus.op_b[4:0];
   assign lt_s  = $signed(bus.op_a) < $signed(bus.op_b);
   assign lt_u  = bus.op_a < bus.op_b;

   // ALU result and branch flag; branch codes return the difference as result.
   always_comb begin
      alu_res = '0;
      br      = 1'b0;
      case (ctrl)
         CTRL_ADD:  alu_res = bus.op_a + bus.op_b;
         CTRL_SUB:  alu_res = diff;
         CTRL_SLL:  alu_res = bus.op_a << shamt;
         CTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
         CTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
         CTRL_XOR:  alu_res = bus.op_a ^ bus.op_b;
         CTRL_SRL:  alu_res = bus.op_a >> shamt;
         CTRL_SRA:  alu_res = $unsigned($signed(bus.op_a) >>> shamt);
         CTRL_OR:   alu_res = bus.op_a | bus.op_b;
         CTRL_AND:  alu_res = bus.op_a & bus.op_b;
         CTRL_BEQ:  begin alu_res = diff; br = (bus.op_a == bus.op_b); end
         CTRL_BNE:  begin alu_res = diff; br = (bus.op_a != bus.op_b); end
         CTRL_BLT:  begin alu_res = diff; br = lt_s;  end
         CTRL_BGE:  begin alu_res = diff; br = !lt_s; end
         CTRL_BLTU: begin alu_res = diff; br = lt_u;  end
         CTRL_BGEU: begin alu_res = diff; br = !lt_u; end
         default:   alu_res = '0;
      endcase
   end

   assign bus.alu_ctrl = ctrl;
   assign bus.alu_o    = alu_res;
   assign bus.br_mark  = br;

   ex_alu_csr_unit_csr_regfile u_csr (
      .clk         (clk),
      .rst         (rst),
      .priv_mode_i (bus.priv_mode),
      .w_en_i      (bus.csr_w_en),
      .w_addr_i    (bus.csr_w_addr),
      .w_data_i    (bus.csr_w_data),
      .r_addr_i    (bus.csr_r_addr),
      .r_data_o    (bus.csr_r_data),
      .mstatus_o   (bus.o_mstatus),
      .mtvec_o     (bus.o_mtvec),
      .mepc_o      (bus.o_mepc),
      .mcause_o    (bus.o_mcause),
      .mtval_o     (bus.o_mtval),
      .satp_o      (bus.o_satp),
      .sepc_o      (bus.o_sepc)
   );

endmodule

// File: tb/tb_ex_alu_csr_unit.sv
// Scoreboard bench for ex_alu_csr_unit: the stimulus process drives a vector just
// after a rising edge and queues the expected outputs; the monitor pops and compares
// them on the following falling edge.
module tb_ex_alu_csr_unit;
   import ex_alu_csr_unit_pkg::*;

   localparam int SEL_CTRL = 0, SEL_ALU = 1, SEL_BR = 2, SEL_RDATA = 3,
                  SEL_MTVEC = 4, SEL_MSTATUS = 5, SEL_MEPC = 6, SEL_MTVAL = 7,
                  SEL_MCAUSE = 8, SEL_SATP = 9, SEL_SEPC = 10;

   typedef struct {
      int          sel;
      string       name;
      logic [31:0] value;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb_q[$];
   int   n_cmp;
   int   n_bad;

   ex_alu_csr_unit_if bus ();

   ex_alu_csr_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] actual(input int sel);
      case (sel)
         SEL_CTRL:    return {28'd0, bus.alu_ctrl};
         SEL_ALU:     return bus.alu_o;
         SEL_BR:      return {31'd0, bus.br_mark};
         SEL_RDATA:   return bus.csr_r_data;
         SEL_MTVEC:   return bus.o_mtvec;
         SEL_MSTATUS: return bus.o_mstatus;
         SEL_MEPC:    return bus.o_mepc;
         SEL_MTVAL:   return bus.o_mtval;
         SEL_MCAUSE:  return bus.o_mcause;
         SEL_SATP:    return bus.o_satp;
         default:     return bus.o_sepc;
      endcase
   endfunction

   // Monitor: compare everything queued for this cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = sb_q.pop_front();
            a = actual(e.sel);
            n_cmp++;
            if (a !== e.value) begin
               n_bad++;
               $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.value);
            end
         end
      end
   end

   task automatic expect_val(input int sel, input string name, input logic [31:0] v);
      exp_t e;
      e.sel = sel; e.name = name; e.value = v;
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_vec(input string name, input logic [2:0] op, input logic [2:0] f3,
                          input logic f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ctrl, input logic [31:0] res, input logic brm);
      step();
      bus.alu_op = op; bus.func3_code = f3; bus.func7_code = f7;
      bus.op_a = a; bus.op_b = b;
      expect_val(SEL_CTRL, {name, ".ctrl"}, {28'd0, ctrl});
      expect_val(SEL_ALU,  {name, ".alu_o"}, res);
      expect_val(SEL_BR,   {name, ".br"}, {31'd0, brm});
   endtask

   task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
      bus.csr_w_en = 1'b1; bus.csr_w_addr = addr; bus.csr_w_data = data;
   endtask

   task automatic expect_views(input string name, input logic [31:0] mtvec, input logic [31:0] mstatus,
                               input logic [31:0] mepc, input logic [31:0] mtval, input logic [31:0] mcause,
                               input logic [31:0] satp, input logic [31:0] sepc);
      expect_val(SEL_MTVEC,   {name, ".mtvec"}, mtvec);
      expect_val(SEL_MSTATUS, {name, ".mstatus"}, mstatus);
      expect_val(SEL_MEPC,    {name, ".mepc"}, mepc);
      expect_val(SEL_MTVAL,   {name, ".mtval"}, mtval);
      expect_val(SEL_MCAUSE,  {name, ".mcause"}, mcause);
      expect_val(SEL_SATP,    {name, ".satp"}, satp);
      expect_val(SEL_SEPC,    {name, ".sepc"}, sepc);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1;
      bus.alu_op = 3'b000; bus.func3_code = 3'b000; bus.func7_code = 1'b0;
      bus.op_a = '0; bus.op_b = '0; bus.priv_mode = PRIV_M;
      bus.csr_w_en = 1'b0; bus.csr_w_addr = '0; bus.csr_w_data = '0; bus.csr_r_addr = '0;
      step();
      step();
      rst = 1'b0;
      expect_views("reset", 0, 0, 0, 0, 0, 0, 0);

      // ALU decode and arithmetic
      alu_vec("r_sub",    3'b010, 3'b000, 1'b1, 32'd5, 32'd7, 4'd1, 32'hFFFF_FFFE, 1'b0);
      alu_vec("r_sra",    3'b010, 3'b101, 1'b1, 32'h8000_0000, 32'h24, 4'd7, 32'hF800_0000, 1'b0);
      alu_vec("r_srl",    3'b010, 3'b101, 1'b0, 32'h8000_0000, 32'h24, 4'd6, 32'h0800_0000, 1'b0);
      alu_vec("i_add_f7", 3'b011, 3'b000, 1'b1, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0);
      alu_vec("i_sra",    3'b011, 3'b101, 1'b1, 32'hF000_0000, 32'd8, 4'd7, 32'hFFF0_0000, 1'b0);
      alu_vec("add_wrap", 3'b000, 3'b111, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b0);
      alu_vec("op1xx",    3'b110, 3'b000, 1'b1, 32'd3, 32'd4, 4'd0, 32'd7, 1'b0);
      alu_vec("r_sll",    3'b010, 3'b001, 1'b0, 32'd1, 32'h3F, 4'd2, 32'h8000_0000, 1'b0);
      alu_vec("r_slt",    3'b010, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1, 1'b0);
      alu_vec("r_sltu",   3'b010, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0, 1'b0);
      alu_vec("r_xor",    3'b010, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd5, 32'hFF00_FF00, 1'b0);
      alu_vec("r_or",     3'b010, 3'b110, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd8, 32'hFFF0_FFF0, 1'b0);
      alu_vec("r_and",    3'b010, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd9, 32'h00F0_00F0, 1'b0);
      // Branch compares
      alu_vec("blt",      3'b001, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd12, 32'hFFFF_FFFE, 1'b1);
      alu_vec("bltu",     3'b001, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd14, 32'hFFFF_FFFE, 1'b0);
      alu_vec("bge",      3'b001, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd13, 32'hFFFF_FFFE, 1'b0);
      alu_vec("bgeu",     3'b001, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd15, 32'hFFFF_FFFE, 1'b1);
      alu_vec("beq",      3'b001, 3'b000, 1'b0, 32'h1234, 32'h1234, 4'd10, 32'd0, 1'b1);
      alu_vec("bne",      3'b001, 3'b001, 1'b0, 32'h1234, 32'h1234, 4'd11, 32'd0, 1'b0);
      alu_vec("br_f3_010",3'b001, 3'b010, 1'b0, 32'd9, 32'd1, 4'd0, 32'd10, 1'b0);

      // CSR write/read timing
      step();
      csr_write(CSR_MTVEC, 32'h8000_1000);
      bus.csr_r_addr = CSR_MTVEC;
      expect_val(SEL_RDATA, "mtvec_same_cycle", 32'd0);
      step();
      bus.csr_w_en = 1'b0;
      expect_val(SEL_RDATA, "mtvec_next_cycle", 32'h8000_1000);
      expect_val(SEL_MTVEC, "o_mtvec", 32'h8000_1000);
      step();
      bus.csr_r_addr = 12'h7C0;
      csr_write(12'h7C0, 32'hFFFF_FFFF);
      expect_val(SEL_RDATA, "unimpl_read", 32'd0);
      step();
      bus.csr_w_en = 1'b0;
      expect_val(SEL_RDATA, "unimpl_after_write", 32'd0);
      expect_views("unimpl_write", 32'h8000_1000, 0, 0, 0, 0, 0, 0);
      csr_write(CSR_MEPC, 32'h1122_3344);
      step();
      csr_write(CSR_MCAUSE, 32'h8000_0007);
      step();
      csr_write(CSR_MTVAL, 32'hDEAD_BEEF);
      step();
      csr_write(CSR_SATP, 32'h8000_0ABC);
      bus.csr_r_addr = CSR_MEPC;
      expect_val(SEL_RDATA, "mepc_read", 32'h1122_3344);
      step();
      bus.csr_w_en = 1'b0;
      bus.csr_r_addr = CSR_SATP;
      expect_val(SEL_RDATA, "satp_read", 32'h8000_0ABC);
      expect_views("filled", 32'h8000_1000, 0, 32'h1122_3344, 32'hDEAD_BEEF, 32'h8000_0007,
                   32'h8000_0ABC, 0);

      // Reset beats a same-edge write
      rst = 1'b1;
      csr_write(CSR_MEPC, 32'h0000_DEAD);
      step();
      rst = 1'b0;
      bus.csr_w_en = 1'b0;
      bus.csr_r_addr = CSR_MEPC;
      expect_val(SEL_RDATA, "rst_mepc_read", 32'd0);
      expect_views("rst_prio", 0, 0, 0, 0, 0, 0, 0);

      // Privilege-gated writes from S mode
      step();
      bus.priv_mode = PRIV_S;
      csr_write(CSR_MSTATUS, 32'hA5A5_A5A5);
      step();
      csr_write(CSR_SEPC, 32'h0000_5EC0);
      step();
      bus.priv_mode = PRIV_U;
      csr_write(CSR_SATP, 32'h0000_0001);
      step();
      bus.csr_w_en = 1'b0;
      bus.priv_mode = PRIV_M;
`ifdef CSR_PRIV_CHECK_EN
      expect_val(SEL_MSTATUS, "priv_s_mstatus", 32'd0);
      expect_val(SEL_SATP,    "priv_u_satp", 32'd0);
`else
      expect_val(SEL_MSTATUS, "priv_s_mstatus", 32'hA5A5_A5A5);
      expect_val(SEL_SATP,    "priv_u_satp", 32'd1);
`endif
      expect_val(SEL_SEPC, "priv_s_sepc", 32'h0000_5EC0);

      // Let the monitor drain, bounded.
      for (int i = 0; i < 5 && sb_q.size() > 0; i++) step();
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0 pending", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
